// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam int          REG_ADDR_W = 5;
  localparam int          WAIT_W     = 16;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID operands and the load sitting in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_uses_rs && (ex_dest == id_rs);
    rt_match = id_uses_rt && (ex_dest == id_rt);
    // Writes to r0 are discarded, so a load into r0 never creates a dependency.
    load_use = ex_mem_read && ex_reg_write && (ex_dest != REG_ZERO) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, squash controls,
// data-memory wait handling and saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              load_use;
  logic              resolve;

  hazard_detect u_hazard_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_dest      (ex_dest),
    .load_use     (load_use)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    stall_d      = stall_q;
    flush_d      = flush_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    resolve      = 1'b0;

    case (state_q)
      INIT: begin
        // The NOPs are only captured once reset has been released.
        if_id_en     = rst_n;
        id_ex_en     = rst_n;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (wait_q != '1) wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(TIMEOUT)) timeout_d = 1'b1;
        if (mem_ready) begin
          resolve = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = INIT;
    endcase

    // Redirect outranks load-use: the dependent instruction is being squashed anyway.
    if (resolve) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (flush_q != '1) flush_d = flush_q + 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if ((state_q != INIT) && !pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
